// File: rtl/minmax_sort4_ctrl_pkg.sv
// Shared types and constants for the 4-word sorter: FSM states and the
// compare-exchange schedule that drives the single shared comparator.
package minmax_sort4_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SORT_STEPS = 6;

    // Lower index of the pair compared at each step, step 0 in the LSBs.
    // The upper index is always lower+1: (0,1) (1,2) (2,3) (0,1) (1,2) (0,1).
    localparam logic [2*SORT_STEPS-1:0] SCHED_LO = {2'd0, 2'd1, 2'd0, 2'd2, 2'd1, 2'd0};

    function automatic logic [1:0] pair_lo(input logic [2:0] step);
        if (int'(step) < SORT_STEPS) begin
            return SCHED_LO[{step, 1'b0} +: 2];
        end
        return 2'd0;
    endfunction

endpackage

// File: rtl/minmax_sort4_ctrl_if.sv
// Input/output val-rdy bundle of the 4-word sorter.
interface minmax_sort4_ctrl_if #(
    parameter int p_nbits = 8
);
    logic               in_val;
    logic               in_rdy;
    logic [p_nbits-1:0] in_data0;
    logic [p_nbits-1:0] in_data1;
    logic [p_nbits-1:0] in_data2;
    logic [p_nbits-1:0] in_data3;
    logic               out_val;
    logic               out_rdy;
    logic [p_nbits-1:0] out_data0;
    logic [p_nbits-1:0] out_data1;
    logic [p_nbits-1:0] out_data2;
    logic [p_nbits-1:0] out_data3;

    modport master (
        output in_val, in_data0, in_data1, in_data2, in_data3, out_rdy,
        input  in_rdy, out_val, out_data0, out_data1, out_data2, out_data3
    );

    modport slave (
        input  in_val, in_data0, in_data1, in_data2, in_data3, out_rdy,
        output in_rdy, out_val, out_data0, out_data1, out_data2, out_data3
    );
endinterface

// File: rtl/minmax_sort4_ctrl_minmax_unit.sv
// Combinational unsigned 2-input compare-exchange.
module minmax_unit #(
    parameter int p_nbits = 8
) (
    input  logic [p_nbits-1:0] in0,
    input  logic [p_nbits-1:0] in1,
    output logic [p_nbits-1:0] min,
    output logic [p_nbits-1:0] max
);
    logic w_swap;

    assign w_swap = (in0 > in1);
    assign min    = w_swap ? in1 : in0;
    assign max    = w_swap ? in0 : in1;
endmodule

// File: rtl/minmax_sort4_ctrl.sv
// Sequential 4-word ascending sorter: one shared min/max unit stepped through
// a fixed 6-step compare-exchange schedule, val/rdy on both sides.
module minmax_sort4_ctrl
    import minmax_sort4_ctrl_pkg::*;
#(
    parameter int p_nbits = 8
) (
    input  logic               clk,
    input  logic               reset,
    minmax_sort4_ctrl_if.slave bus
);
    state_t             r_state;
    state_t             w_state_next;
    logic [2:0]         r_step;
    logic [2:0]         w_step_next;
    logic [p_nbits-1:0] w_in   [4];
    logic [p_nbits-1:0] w_word [4];
    logic [1:0]         w_lo;
    logic [1:0]         w_hi;
    logic [p_nbits-1:0] w_a;
    logic [p_nbits-1:0] w_b;
    logic [p_nbits-1:0] w_min;
    logic [p_nbits-1:0] w_max;
    logic               w_accept;
    logic               w_sorting;

    assign w_in[0] = bus.in_data0;
    assign w_in[1] = bus.in_data1;
    assign w_in[2] = bus.in_data2;
    assign w_in[3] = bus.in_data3;

    assign w_accept  = (r_state == IDLE) && bus.in_val;
    assign w_sorting = (r_state == SORT);

    assign w_lo = pair_lo(r_step);
    assign w_hi = w_lo + 2'd1;
    assign w_a  = w_word[w_lo];
    assign w_b  = w_word[w_hi];

    minmax_unit #(
        .p_nbits (p_nbits)
    ) u_minmax (
        .in0 (w_a),
        .in1 (w_b),
        .min (w_min),
        .max (w_max)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_step  <= 3'd0;
        end else begin
            r_state <= w_state_next;
            r_step  <= w_step_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_step_next  = r_step;
        case (r_state)
            IDLE: begin
                if (bus.in_val) begin
                    w_state_next = SORT;
                    w_step_next  = 3'd0;
                end
            end
            SORT: begin
                if (r_step == 3'(SORT_STEPS - 1)) begin
                    w_state_next = DONE;
                    w_step_next  = 3'd0;
                end else begin
                    w_step_next = r_step + 3'd1;
                end
            end
            DONE: begin
                if (bus.out_rdy) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_step_next  = 3'd0;
            end
        endcase
    end

    // Each word only ever takes its input, the min (as lower index) or the max.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_word
            logic [p_nbits-1:0] r_word;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_word <= '0;
                end else if (w_accept) begin
                    r_word <= w_in[gi];
                end else if (w_sorting) begin
                    if (w_lo == 2'(gi)) begin
                        r_word <= w_min;
                    end else if (w_hi == 2'(gi)) begin
                        r_word <= w_max;
                    end
                end
            end

            assign w_word[gi] = r_word;
        end
    endgenerate

    assign bus.in_rdy    = (r_state == IDLE);
    assign bus.out_val   = (r_state == DONE);
    assign bus.out_data0 = w_word[0];
    assign bus.out_data1 = w_word[1];
    assign bus.out_data2 = w_word[2];
    assign bus.out_data3 = w_word[3];
endmodule

// File: tb/tb_minmax_sort4_ctrl.sv
// Bench for minmax_sort4_ctrl: directed corner bundles plus a randomized
// back-to-back run scored against a queue-sort reference.
module tb_minmax_sort4_ctrl;
    localparam int W = 8;
    typedef logic [3:0][W-1:0] bundle_t;

    logic clk = 1'b0;
    logic reset;

    minmax_sort4_ctrl_if #(.p_nbits(W)) bus ();

    minmax_sort4_ctrl #(.p_nbits(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_in     = 0;
    int n_out    = 0;
    bit mon_en   = 1'b0;
    bundle_t exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic bundle_t golden(input bundle_t d);
        int      q [$];
        bundle_t s;
        for (int k = 0; k < 4; k++) q.push_back(int'(d[k]));
        q.sort();
        for (int k = 0; k < 4; k++) s[k] = W'(q[k]);
        return s;
    endfunction

    function automatic bundle_t observed();
        bundle_t o;
        o[0] = bus.out_data0;
        o[1] = bus.out_data1;
        o[2] = bus.out_data2;
        o[3] = bus.out_data3;
        return o;
    endfunction

    function automatic bundle_t mk(input int a, input int b, input int c, input int d);
        bundle_t x;
        x[0] = W'(a); x[1] = W'(b); x[2] = W'(c); x[3] = W'(d);
        return x;
    endfunction

    task automatic drive(input bundle_t d);
        bus.in_data0 = d[0];
        bus.in_data1 = d[1];
        bus.in_data2 = d[2];
        bus.in_data3 = d[3];
    endtask

    task automatic check_bundle(input string tag, input bundle_t got, input bundle_t exp);
        for (int k = 0; k < 4; k++) check($sformatf("%s_d%0d", tag, k), 32'(got[k]), 32'(exp[k]));
        $display("%s: out={%0d,%0d,%0d,%0d} exp={%0d,%0d,%0d,%0d}", tag,
                 got[0], got[1], got[2], got[3], exp[0], exp[1], exp[2], exp[3]);
    endtask

    // Presents d and waits (bounded) for the accepting edge; returns #1 after it.
    task automatic accept(input string tag, input bundle_t d);
        int t = 0;
        drive(d);
        bus.in_val = 1'b1;
        while (!bus.in_rdy && t < 40) begin
            @(posedge clk); #1; t++;
        end
        check({tag, "_rdy_timeout"}, 32'(bus.in_rdy), 32'd1);
        @(posedge clk); #1;
    endtask

    // Called #1 after the accept edge: out_val must appear 6 edges later,
    // i.e. in the 7th cycle after the accept cycle.
    task automatic finish_bundle(input string tag, input bundle_t d);
        int edges = 0;
        while (!bus.out_val && edges < 30) begin
            @(posedge clk); #1; edges++;
        end
        check({tag, "_latency"}, 32'(edges), 32'd6);
        check_bundle(tag, observed(), golden(d));
    endtask

    task automatic run_one(input string tag, input bundle_t d);
        bus.out_rdy = 1'b1;
        accept(tag, d);
        bus.in_val = 1'b0;
        finish_bundle(tag, d);
        @(posedge clk); #1;
        check({tag, "_idle_rdy"}, 32'(bus.in_rdy), 32'd1);
        check({tag, "_idle_val"}, 32'(bus.out_val), 32'd0);
    endtask

    always @(negedge clk) begin
        if (mon_en && bus.out_val && bus.out_rdy) begin
            n_out++;
            if (exp_q.size() == 0) begin
                check("rand_unexpected_out", 32'd1, 32'd0);
            end else begin
                check_bundle($sformatf("rand%0d", n_out), observed(), exp_q.pop_front());
            end
        end
    end

    initial begin
        bundle_t held;
        bundle_t d2;
        bundle_t d;
        bit      rdy_seen;
        int      t;

        reset       = 1'b1;
        bus.in_val  = 1'b0;
        bus.out_rdy = 1'b1;
        drive(mk(0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_rdy", 32'(bus.in_rdy), 32'd1);
        check("rst_out_val", 32'(bus.out_val), 32'd0);
        check_bundle("rst_data", observed(), mk(0, 0, 0, 0));
        reset = 1'b0;
        @(posedge clk); #1;

        // Asynchronous reset in the middle of sorting
        accept("midrst", mk(9, 3, 7, 1));
        bus.in_val = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        #1;
        check("midrst_in_rdy", 32'(bus.in_rdy), 32'd1);
        check("midrst_out_val", 32'(bus.out_val), 32'd0);
        check_bundle("midrst_data", observed(), mk(0, 0, 0, 0));
        #2;
        reset = 1'b0;
        @(posedge clk); #1;

        run_one("basic", mk(4, 3, 2, 1));
        run_one("sorted_dup", mk(0, 0, 255, 255));
        run_one("all_equal", mk(5, 5, 5, 5));
        run_one("unsigned_msb", mk(128, 127, 255, 0));
        run_one("after_rst", mk(9, 3, 7, 1));

        // Backpressure in DONE with in_val held high
        held = mk(200, 17, 99, 17);
        d2   = mk(1, 250, 128, 64);
        bus.out_rdy = 1'b0;
        accept("bp", held);
        t = 0;
        while (!bus.out_val && t < 30) begin
            @(posedge clk); #1; t++;
        end
        check("bp_latency", 32'(t), 32'd6);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            check($sformatf("bp_busy_c%0d", c), 32'(bus.in_rdy), 32'd0);
            check($sformatf("bp_val_c%0d", c), 32'(bus.out_val), 32'd1);
            check($sformatf("bp_stable_c%0d", c), 32'(observed()), 32'(golden(held)));
        end
        drive(d2);
        bus.out_rdy = 1'b1;
        @(posedge clk); #1;
        check("bp_release_rdy", 32'(bus.in_rdy), 32'd1);
        check("bp_release_val", 32'(bus.out_val), 32'd0);
        @(posedge clk); #1;
        check("bp_next_accepted", 32'(bus.in_rdy), 32'd0);
        bus.in_val = 1'b0;
        finish_bundle("bp_next", d2);
        @(posedge clk); #1;

        // Randomized back-to-back bundles with random consumer stalls
        mon_en = 1'b1;
        bus.in_val = 1'b1;
        for (int i = 0; i < 20; i++) begin
            for (int k = 0; k < 4; k++) d[k] = W'($urandom_range(0, 255));
            drive(d);
            t = 0;
            rdy_seen = 1'b0;
            while (!rdy_seen && t < 100) begin
                @(negedge clk);
                rdy_seen = bus.in_rdy;
                @(posedge clk); #1;
                bus.out_rdy = ($urandom_range(0, 3) != 0);
                t++;
            end
            check($sformatf("rand_accept%0d", i), 32'(rdy_seen), 32'd1);
            if (rdy_seen) begin
                exp_q.push_back(golden(d));
                n_in++;
            end
        end
        bus.in_val  = 1'b0;
        bus.out_rdy = 1'b1;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(posedge clk); #1; t++;
        end
        check("rand_drain", 32'(exp_q.size()), 32'd0);
        check("rand_count", 32'(n_out), 32'(n_in));
        mon_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
